// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared raster-timing constants for the VGA blocks.
//   - Default 640x480@60 porch/sync widths (pixels and lines).
//   - H_TOTAL / V_TOTAL for the default mode.
//   - Sync polarity (both syncs are active low in this mode).
//   - SCREEN_WIDTH, the common width of the x/y coordinate buses.
package vga_timing_pkg;

    localparam int SCREEN_WIDTH = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div
// Divides sys_clk down to a one-cycle pixel-rate strobe.
// Ports:
//   sys_clk  in   system clock
//   sys_rst  in   synchronous, active-high reset
//   p_tick   out  high for one sys_clk cycle every PIX_DIV cycles
// p_tick is a strobe, not a handshake: there is no ready; consumers advance
// on any rising sys_clk edge where p_tick is high.
module pixel_tick_div #(
    parameter int PIX_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic p_tick
);

    // At least one bit even for PIX_DIV=1, where the counter is constant 0
    // and p_tick stays high.
    localparam int CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(PIX_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing generator feeding the pixel generator and the VGA port.
// Ports:
//   sys_clk      in   system clock (100 MHz)
//   sys_rst      in   synchronous, active-high reset
//   p_tick       out  one-cycle pixel-advance strobe
//   x, y         out  current h/v count (registers, zero latency)
//   video_on     out  x/y inside the visible area
//   hsync, vsync out  registered syncs, active low, aligned with x/y
//   frame_start  out  one-cycle pulse on the last pixel of each frame
//   frame_cnt    out  completed-frame count
// Build option: define VGA_SYNC_FRAME_CNT_EN to build the frame counter;
// otherwise frame_cnt is tied to zero and the port is kept.
module vga_sync_gen #(
    parameter int PIX_DIV         = 4,
    parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY_DEF,
    parameter int H_FRONT         = vga_timing_pkg::H_FRONT_DEF,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC_DEF,
    parameter int H_BACK          = vga_timing_pkg::H_BACK_DEF,
    parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY_DEF,
    parameter int V_FRONT         = vga_timing_pkg::V_FRONT_DEF,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC_DEF,
    parameter int V_BACK          = vga_timing_pkg::V_BACK_DEF,
    parameter int SCREEN_WIDTH    = vga_timing_pkg::SCREEN_WIDTH,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    output logic                       p_tick,
    output logic [SCREEN_WIDTH-1:0]    x,
    output logic [SCREEN_WIDTH-1:0]    y,
    output logic                       video_on,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

    import vga_timing_pkg::*;

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOT >= (1 << SCREEN_WIDTH) || V_TOT >= (1 << SCREEN_WIDTH)) begin : g_width_check
        $error("vga_sync_gen: H/V total does not fit in SCREEN_WIDTH bits");
    end
    if (PIX_DIV < 1) begin : g_div_check
        $error("vga_sync_gen: PIX_DIV must be at least 1");
    end

    localparam logic [SCREEN_WIDTH-1:0] H_LAST   = SCREEN_WIDTH'(H_TOT - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_LAST   = SCREEN_WIDTH'(V_TOT - 1);
    localparam logic [SCREEN_WIDTH-1:0] H_VIS    = SCREEN_WIDTH'(H_DISPLAY);
    localparam logic [SCREEN_WIDTH-1:0] V_VIS    = SCREEN_WIDTH'(V_DISPLAY);
    localparam logic [SCREEN_WIDTH-1:0] HS_START = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [SCREEN_WIDTH-1:0] HS_END   = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [SCREEN_WIDTH-1:0] VS_START = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
    localparam logic [SCREEN_WIDTH-1:0] VS_END   = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [SCREEN_WIDTH-1:0] h_cnt;
    logic [SCREEN_WIDTH-1:0] v_cnt;
    logic [SCREEN_WIDTH-1:0] h_next;
    logic [SCREEN_WIDTH-1:0] v_next;
    logic                    h_last;
    logic                    v_last;
    logic                    hsync_next;
    logic                    vsync_next;

    pixel_tick_div #(
        .PIX_DIV (PIX_DIV)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .p_tick  (p_tick)
    );

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Line end and frame end can land on the same tick; both wrap together.
    always_comb begin
        h_next = h_last ? '0 : h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_last) begin
            v_next = v_last ? '0 : v_cnt + 1'b1;
        end
    end

    // Syncs are decoded from the next count and loaded on the same edge as
    // the counters, so they line up with x/y without a pipeline stage.
    assign hsync_next = (h_next >= HS_START && h_next < HS_END) ? SYNC_ACTIVE : SYNC_IDLE;
    assign vsync_next = (v_next >= VS_START && v_next < VS_END) ? SYNC_ACTIVE : SYNC_IDLE;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
        end else if (p_tick) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            hsync <= hsync_next;
            vsync <= vsync_next;
        end
    end

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_start = p_tick & h_last & v_last;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that sits directly upstream of the pixel generator.
- Divides sys_clk down to a pixel tick and runs horizontal and vertical counters.
- Produces hsync/vsync for the VGA port, and video_on plus x/y for the pixel generator.
- Emits a one-cycle frame_start pulse so game logic (character position, debug sequences) updates between frames.

Parameters:
- PIX_DIV, 4: sys_clk cycles per pixel (100 MHz / 4 = 25 MHz); legal values are ≥1.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- SCREEN_WIDTH, 10: width of x and y.
- FRAME_CNT_WIDTH, 16: width of frame_cnt.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  reset; synchronous, active-high.
- p_tick  out  1  one-sys_clk pulse marking a pixel advance.
- x  out  SCREEN_WIDTH  horizontal count, 0..H_TOTAL-1.
- y  out  SCREEN_WIDTH  vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- frame_start  out  1  one-sys_clk pulse on the last pixel of a frame.
- frame_cnt  out  FRAME_CNT_WIDTH  completed-frame count; see Optional Feature.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Derived constants:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
  - Both must fit in SCREEN_WIDTH bits; this is checked at elaboration.
- Divider:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - p_tick is a combinational decode of div_cnt==PIX_DIV-1.
  - With PIX_DIV=1, p_tick is constantly 1 outside reset.
- Horizontal counter h_cnt:
  - Advances only on the edge where p_tick=1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter v_cnt:
  - Advances only on the edge where p_tick=1 and h_cnt==H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0.
- x and y are the h_cnt/v_cnt registers driven directly, so the pixel generator sees zero latency.
- video_on and frame_start are combinational decodes of the registers.
- hsync and vsync are registered:
  - Each is loaded on the p_tick edge from the next-count decode, so it is aligned with x/y. There is no extra pipeline delay.
  - hsync=0 when H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC, i.e. h in 656..751.
  - vsync=0 when V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC, i.e. v in 490..491.
- frame_start = p_tick & (h_cnt==H_TOTAL-1) & (v_cnt==V_TOTAL-1): exactly one pulse per frame, and the next pixel is (0,0).
- All outputs are stable for PIX_DIV cycles between ticks.
- Reset, including mid-frame:
  - Next edge gives div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, frame_cnt=0.
  - Outputs then read p_tick=0 (PIX_DIV>1), x=0, y=0, video_on=1, frame_start=0.
  - The first tick after release occurs PIX_DIV cycles later.
- Line end and frame end occurring on the same tick: both counters wrap on the same edge.
- No other inputs exist, so there are no further simultaneous-event cases.

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - frame_cnt increments by 1 on every edge where frame_start=1.
  - It wraps modulo 2^FRAME_CNT_WIDTH and resets to 0.
  - It is used for animation pacing of the character sprite.
- Undefined:
  - The counter register is not built and frame_cnt is tied to 0.
  - The port is kept so integration is unchanged.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 porch/sync localparams;
  - H_TOTAL and V_TOTAL;
  - sync-polarity constants (active low);
  - the shared SCREEN_WIDTH.
- Sub-module pixel_tick_div: parameter PIX_DIV; ports sys_clk, sys_rst, p_tick. It is reused by other pixel-rate blocks.
- Counters and sync decode stay in vga_sync_gen.

Test Plan:
- Reset check: hold sys_rst 3 cycles then release → x=0, y=0, hsync=1, vsync=1, video_on=1; first p_tick on the 4th cycle after release; x=1 on the following edge.
- Tick cadence: run 400 cycles → exactly 100 p_tick pulses, each 1 cycle wide, spaced 4 cycles apart; x changes only on tick edges.
- Line timing: observe one line → hsync low while x=656..751 (96 ticks = 384 cycles); video_on falls at x=640; x wraps 799→0 and y increments on that same edge.
- Frame timing: run one full frame (420000 ticks) → vsync low while y=490..491; exactly one frame_start pulse, at x=799 and y=524; next outputs are x=0, y=0; with the macro defined, frame_cnt reads 1.
- Mid-frame reset: assert sys_rst at x=300, y=200 for 1 cycle → next edge gives x=0, y=0, hsync=1, vsync=1, frame_cnt=0; no frame_start is produced.
- Parameter variant: PIX_DIV=1 with FRAME_CNT_WIDTH=2 → p_tick constantly high; frame_cnt sequence 1,2,3,0 over four frames.
